// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, redirect source codes and datapath width.
package pipe_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic SRC_BRANCH = 1'b0;
    localparam logic SRC_TRAP   = 1'b1;
endpackage

// File: rtl/pc_redirect_ctrl_perf_counter.sv
// perf_counter: free-running wrap-around event counter with synchronous clear.
module perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (inc) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates branch/trap redirects, hands one at a time to fetch,
// and holds pipeline flush for a fixed window after each accepted redirect.
module pc_redirect_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN         = pipe_ctrl_pkg::XLEN,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [XLEN-1:0]  br_target,
    input  logic [XLEN-1:0]  br_pc,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_target,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             redirect_src,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             busy,
    output logic [XLEN-1:0]  last_br_pc,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    logic [1:0]      state, state_nxt;
    logic [3:0]      fcnt, fcnt_nxt;
    logic [XLEN-1:0] pc_nxt, br_pc_q, br_pc_nxt;
    logic            src_nxt, hs, drop;

    assign hs = (state == S_REDIRECT) && fetch_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            fcnt         <= '0;
            redirect_pc  <= '0;
            redirect_src <= SRC_BRANCH;
            br_pc_q      <= '0;
            last_br_pc   <= '0;
        end else begin
            state        <= state_nxt;
            fcnt         <= fcnt_nxt;
            redirect_pc  <= pc_nxt;
            redirect_src <= src_nxt;
            br_pc_q      <= br_pc_nxt;
            if (hs && redirect_src == SRC_BRANCH) last_br_pc <= br_pc_q;
        end
    end

    // Bit 0 of every latched target is cleared (JALR alignment).
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        pc_nxt    = redirect_pc;
        src_nxt   = redirect_src;
        br_pc_nxt = br_pc_q;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                drop = br_valid && trap_valid;
                if (trap_valid) begin
                    state_nxt = S_REDIRECT;
                    pc_nxt    = {trap_target[XLEN-1:1], 1'b0};
                    src_nxt   = SRC_TRAP;
                end else if (br_valid) begin
                    state_nxt = S_REDIRECT;
                    pc_nxt    = {br_target[XLEN-1:1], 1'b0};
                    src_nxt   = SRC_BRANCH;
                    br_pc_nxt = br_pc;
                end
            end
            S_REDIRECT: begin
                drop = br_valid;
                if (fetch_ready) begin
                    state_nxt = S_FLUSH;
                    fcnt_nxt  = 4'(FLUSH_CYCLES);
                end
                // A trap preempting a branch keeps us offering; an accepted branch still counts.
                if (trap_valid && redirect_src == SRC_BRANCH) begin
                    state_nxt = S_REDIRECT;
                    pc_nxt    = {trap_target[XLEN-1:1], 1'b0};
                    src_nxt   = SRC_TRAP;
                end
            end
            S_FLUSH: begin
                drop     = br_valid;
                fcnt_nxt = fcnt - 4'd1;
                if (trap_valid) begin
                    state_nxt = S_REDIRECT;
                    pc_nxt    = {trap_target[XLEN-1:1], 1'b0};
                    src_nxt   = SRC_TRAP;
                end else if (fcnt == 4'd1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        redirect_valid = state == S_REDIRECT;
        busy           = state != S_IDLE;
        flush_if_id    = busy;
        flush_id_ex    = busy;
    end

    perf_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk(clk), .rst(rst), .inc(hs), .cnt(redirect_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk(clk), .rst(rst), .inc(drop), .cnt(drop_cnt)
    );
endmodule
